// File: rtl/screen_mirror.sv
// Screen mirror for the VGA renderer: snoops CPU writes to the screen window,
// queues them in a small FIFO, commits them to a 1024x8 RAM and serves 1-cycle reads.
module screen_mirror #(
  parameter logic [15:0] BASE_ADDR      = 16'h0200,
  parameter int          FIFO_DEPTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_ready,
  input  logic        clear_req,
  input  logic [7:0]  clear_value,
  output logic        busy,
  output logic        overflow,
  input  logic        screen_read_en,
  input  logic [10:0] screen_read_addr,
  output logic [7:0]  screen_read_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [9:0]    clear_index;
  logic [7:0]    clear_data;

  logic [7:0]    ram [0:1023];

  logic [9:0]    fifo_index [FIFO_DEPTH];
  logic [7:0]    fifo_data  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic [15:0]   offset;
  logic          in_window;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          ram_we;
  logic [9:0]    ram_waddr;
  logic [7:0]    ram_wdata;

  logic          read_in_range;
  logic [9:0]    read_index;

  // Lower bound is checked separately so the subtraction wrap cannot alias below the window.
  assign offset    = cpu_addr - BASE_ADDR;
  assign in_window = (cpu_addr >= BASE_ADDR) && (offset < 16'd1024);

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign cpu_ready = !full;
  assign push      = cpu_we && in_window && !full;
  assign pop       = !empty && (state == IDLE);

  // busy is the clear FSM state, forced low while reset is held.
  assign busy      = (state == CLEAR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clear_index <= '0;
      clear_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state       <= CLEAR;
            clear_index <= '0;
            clear_data  <= clear_value;
          end
        end
        CLEAR: begin
          clear_index <= clear_index + 10'd1;
          if (clear_index == 10'd1023) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cpu_we && in_window && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_index[wr_ptr] <= offset[9:0];
      fifo_data[wr_ptr]  <= cpu_dout;
    end
  end

  // The single RAM write port belongs to the clear engine while it runs, else to the FIFO.
  assign ram_we    = !reset && ((state == CLEAR) || pop);
  assign ram_waddr = (state == CLEAR) ? clear_index : fifo_index[rd_ptr];
  assign ram_wdata = (state == CLEAR) ? clear_data  : fifo_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign read_in_range = (screen_read_addr >= 11'h200) && (screen_read_addr < 11'h600);
  assign read_index    = screen_read_addr[9:0] - 10'h200;

  // Read sees the pre-write contents on a same-index collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      screen_read_data <= 8'h00;
    end else if (screen_read_en) begin
      screen_read_data <= read_in_range ? ram[read_index] : 8'h00;
    end
  end

endmodule

// File: tb/tb_screen_mirror.sv
// Directed bench for screen_mirror: reset clear, window decode, read port table,
// clear with queued writes, FIFO overflow, read collision and reset mid-clear.
module tb_screen_mirror;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_ready;
  logic        clear_req;
  logic [7:0]  clear_value;
  logic        busy;
  logic        overflow;
  logic        screen_read_en;
  logic [10:0] screen_read_addr;
  logic [7:0]  screen_read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        en;
    logic [10:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t rv [11];

  screen_mirror dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_addr         (cpu_addr),
    .cpu_dout         (cpu_dout),
    .cpu_we           (cpu_we),
    .cpu_ready        (cpu_ready),
    .clear_req        (clear_req),
    .clear_value      (clear_value),
    .busy             (busy),
    .overflow         (overflow),
    .screen_read_en   (screen_read_en),
    .screen_read_addr (screen_read_addr),
    .screen_read_data (screen_read_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_we   = 1'b1;
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic start_clear(input logic [7:0] v);
    clear_value = v;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [10:0] a, input logic [7:0] exp);
    screen_read_en   = 1'b1;
    screen_read_addr = a;
    tick();
    screen_read_en   = 1'b0;
    check(name, {8'h00, screen_read_data}, {8'h00, exp});
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int c;

    rv[0]  = '{"rd_345",      1'b1, 11'h345, 8'hA7};
    rv[1]  = '{"rd_200",      1'b1, 11'h200, 8'h11};
    rv[2]  = '{"rd_5ff",      1'b1, 11'h5FF, 8'h3C};
    rv[3]  = '{"rd_3ff",      1'b1, 11'h3FF, 8'h00};
    rv[4]  = '{"rd_1ff_low",  1'b1, 11'h1FF, 8'h00};
    rv[5]  = '{"rd_600_high", 1'b1, 11'h600, 8'h00};
    rv[6]  = '{"hold_zero",   1'b0, 11'h345, 8'h00};
    rv[7]  = '{"rd_5ff_2",    1'b1, 11'h5FF, 8'h3C};
    rv[8]  = '{"hold_3c",     1'b0, 11'h200, 8'h3C};
    rv[9]  = '{"rd_7ff_high", 1'b1, 11'h7FF, 8'h00};
    rv[10] = '{"rd_201",      1'b1, 11'h201, 8'h00};

    reset = 1'b1;
    cpu_addr = '0;
    cpu_dout = '0;
    cpu_we = 1'b0;
    clear_req = 1'b0;
    clear_value = '0;
    screen_read_en = 1'b0;
    screen_read_addr = '0;
    repeat (3) tick();

    // reset state and power-on clear
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ready", {15'd0, cpu_ready}, 16'd1);
    check("rst_overflow", {15'd0, overflow}, 16'd0);
    check("rst_read_data", {8'h00, screen_read_data}, 16'h0000);
    reset = 1'b0;
    #1;
    check("release_busy", {15'd0, busy}, 16'd1);
    wait_idle(c);
    check("reset_clear_cycles", 16'(c), 16'd1024);
    read_check("rc_200", 11'h200, 8'h00);
    read_check("rc_3ff", 11'h3FF, 8'h00);
    read_check("rc_5ff", 11'h5FF, 8'h00);

    // single writes, window decode; aliasing writes must not land
    cpu_write(16'h0345, 8'hA7);
    tick();
    read_check("single_345", 11'h345, 8'hA7);
    cpu_write(16'h0200, 8'h11);
    cpu_write(16'h0600, 8'h55);
    cpu_write(16'h05FF, 8'h3C);
    cpu_write(16'h01FF, 8'h77);
    repeat (2) tick();
    check("no_overflow_oow", {15'd0, overflow}, 16'd0);
    check("ready_idle", {15'd0, cpu_ready}, 16'd1);
    for (int i = 0; i < 11; i++) begin
      screen_read_en   = rv[i].en;
      screen_read_addr = rv[i].addr;
      tick();
      check(rv[i].name, {8'h00, screen_read_data}, {8'h00, rv[i].exp});
    end
    screen_read_en = 1'b0;

    // clear with writes queued during it; a second request is ignored
    start_clear(8'h0E);
    check("clr_busy", {15'd0, busy}, 16'd1);
    cpu_write(16'h0200, 8'h01);
    cpu_write(16'h0201, 8'h02);
    cpu_write(16'h0200, 8'h03);
    start_clear(8'hFF);
    wait_idle(c);
    check("clr_cycles", 16'(c + 4), 16'd1024);
    repeat (2) tick();
    read_check("clr_201", 11'h201, 8'h02);
    read_check("clr_202", 11'h202, 8'h0E);
    read_check("clr_200", 11'h200, 8'h03);
    read_check("clr_5ff", 11'h5FF, 8'h0E);
    read_check("clr_345", 11'h345, 8'h0E);

    // FIFO overflow during a clear
    start_clear(8'h5A);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("ready_w%0d", i), {15'd0, cpu_ready}, (i < 8) ? 16'd1 : 16'd0);
      if (i == 8) check("overflow_pre", {15'd0, overflow}, 16'd0);
      cpu_write(16'h0210 + 16'(i), 8'h10 + 8'(i));
    end
    check("overflow_set", {15'd0, overflow}, 16'd1);
    wait_idle(c);
    check("ovf_clr_cycles", 16'(c + 10), 16'd1024);
    check("ready_full_after_clear", {15'd0, cpu_ready}, 16'd0);
    tick();
    check("ready_after_pop", {15'd0, cpu_ready}, 16'd1);
    repeat (8) tick();
    for (int i = 0; i < 8; i++)
      read_check($sformatf("ovf_%0h", 16'h210 + i), 11'h210 + 11'(i), 8'h10 + 8'(i));
    read_check("ovf_218", 11'h218, 8'h5A);
    read_check("ovf_219", 11'h219, 8'h5A);
    check("overflow_sticky", {15'd0, overflow}, 16'd1);

    // read colliding with the commit to the same index
    cpu_write(16'h0300, 8'hC3);
    screen_read_en   = 1'b1;
    screen_read_addr = 11'h300;
    tick();
    check("rdw_old", {8'h00, screen_read_data}, 16'h005A);
    tick();
    check("rdw_new", {8'h00, screen_read_data}, 16'h00C3);
    screen_read_en = 1'b0;

    // reset mid-clear with entries queued
    start_clear(8'h22);
    for (int i = 0; i < 4; i++) cpu_write(16'h0400 + 16'(i), 8'h40 + 8'(i));
    repeat (495) tick();
    check("mid_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, cpu_ready}, 16'd1);
    check("mid_rst_overflow", {15'd0, overflow}, 16'd0);
    check("mid_rst_read_data", {8'h00, screen_read_data}, 16'h0000);
    tick();
    check("mid_rst_busy_held", {15'd0, busy}, 16'd0);
    reset = 1'b0;
    #1;
    check("mid_release_busy", {15'd0, busy}, 16'd1);
    wait_idle(c);
    check("mid_restart_cycles", 16'(c), 16'd1024);
    repeat (3) tick();
    for (int i = 0; i < 4; i++)
      read_check($sformatf("discard_%0h", 16'h400 + i), 11'h400 + 11'(i), 8'h00);
    read_check("mid_200", 11'h200, 8'h00);
    read_check("mid_5ff", 11'h5FF, 8'h00);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
